// File: rtl/des_pkg.sv
// DES permutation/S-box tables, key-schedule shifts and the Feistel f function.
// Table entries use FIPS-46 1-based numbering; FIPS bit 1 is the vector MSB.
package des_pkg;
  typedef logic [31:0] half_t;
  typedef logic [47:0] subkey_t;
  typedef logic [27:0] cd_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
  localparam int E_T [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Each box is row-major: entry = row*16 + col.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return o;
  endfunction

  function automatic subkey_t pc2(input cd_t c, input cd_t d);
    logic [55:0] cd;
    subkey_t o;
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return o;
  endfunction

  function automatic cd_t rotl(input cd_t x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic cd_t rotr(input cd_t x, input int n);
    return (x >> n) | (x << (28 - n));
  endfunction

  function automatic half_t des_f(input half_t r, input subkey_t k);
    subkey_t x;
    half_t s, o;
    logic [5:0] b;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
    x = x ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = 6'(x >> (42 - 6 * i));
      s = {s[27:0], 4'(SBOX[i][{b[5], b[0], b[4:1]}])};
    end
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_T[i])];
    return o;
  endfunction
endpackage

// File: rtl/des_round.sv
// One combinational DES round: key-schedule rotation, subkey selection and Feistel step.
module des_round
  import des_pkg::*;
(
  input  half_t      l,
  input  half_t      r,
  input  cd_t        c,
  input  cd_t        d,
  input  logic [3:0] idx,
  input  logic       dec,
  output half_t      l_nxt,
  output half_t      r_nxt,
  output cd_t        c_nxt,
  output cd_t        d_nxt
);
  cd_t c_rot, d_rot;

  // Decrypt walks the schedule backwards; 0 - idx wraps to 16 - idx.
  always_comb begin
    c_rot = c;
    d_rot = d;
    if (!dec) begin
      c_rot = rotl(c, SHIFT_T[idx]);
      d_rot = rotl(d, SHIFT_T[idx]);
    end else if (idx != 4'd0) begin
      c_rot = rotr(c, SHIFT_T[4'd0 - idx]);
      d_rot = rotr(d, SHIFT_T[4'd0 - idx]);
    end
  end

  assign l_nxt = r;
  assign r_nxt = l ^ des_f(r, pc2(c_rot, d_rot));
  assign c_nxt = c_rot;
  assign d_nxt = d_rot;
endmodule

// File: rtl/des_iterative_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE chained rounds per clock, valid/ready on both sides.
// Result appears 16/ROUNDS_PER_CYCLE clocks after the accept edge, then sits in DONE.
module des_iterative_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int OUT_REG          = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  half_t       l_q, r_q;
  cd_t         c_q, d_q;
  logic        dec_q;
  logic [63:0] dout_q;
  logic        accept, last;

  half_t [ROUNDS_PER_CYCLE:0] l_ch, r_ch;
  cd_t   [ROUNDS_PER_CYCLE:0] c_ch, d_ch;

  assign l_ch[0] = l_q;
  assign r_ch[0] = r_q;
  assign c_ch[0] = c_q;
  assign d_ch[0] = d_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
    des_round u_rnd (
      .l(l_ch[g]), .r(r_ch[g]), .c(c_ch[g]), .d(d_ch[g]),
      .idx(cnt[3:0] + 4'(g)), .dec(dec_q),
      .l_nxt(l_ch[g+1]), .r_nxt(r_ch[g+1]), .c_nxt(c_ch[g+1]), .d_nxt(d_ch[g+1])
    );
  end

  assign last   = (cnt + 5'(ROUNDS_PER_CYCLE)) == 5'd16;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = rst_n & out_ready;
        if (out_ready) state_nxt = in_valid ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      dec_q  <= 1'b0;
      dout_q <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip(data_in);
      {c_q, d_q} <= pc1(key_in);
      dec_q      <= decrypt;
      cnt        <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt + 5'(ROUNDS_PER_CYCLE);
      c_q <= c_ch[ROUNDS_PER_CYCLE];
      d_q <= d_ch[ROUNDS_PER_CYCLE];
      if (last) begin
        // Final swap is stored so L/R already hold the pre-output block.
        l_q    <= r_ch[ROUNDS_PER_CYCLE];
        r_q    <= l_ch[ROUNDS_PER_CYCLE];
        dout_q <= fp({r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]});
      end else begin
        l_q <= l_ch[ROUNDS_PER_CYCLE];
        r_q <= r_ch[ROUNDS_PER_CYCLE];
      end
    end

  assign data_out = (OUT_REG != 0) ? dout_q : fp({l_q, r_q});
endmodule

// File: tb/tb_des_iterative_core.sv
// Directed known-answer, handshake and reset tests plus randomized runs against a local DES model.
module tb_des_iterative_core;
  localparam int RPCS [3] = '{1, 4, 16};
  localparam int LATS [3] = '{17, 5, 2};
  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2 = 64'h8787878787878787;
  localparam logic [63:0] PAR = 64'h0101010101010101;

  localparam byte M_IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
    64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,
    63,55,47,39,31,23,15,7};
  localparam byte M_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
    19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam byte M_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam byte M_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,
    19,13,30,6,22,11,4,25};
  localparam logic [255:0] M_SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic        clk = 1'b0, rst_n = 1'b0, decrypt = 1'b0;
  logic [2:0]  in_valid = '0, out_ready = '0;
  logic [2:0]  in_ready, out_valid, busy;
  logic [63:0] data_in = '0, key_in = '0;
  logic [63:0] dout [3];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    des_iterative_core #(.ROUNDS_PER_CYCLE(RPCS[g]), .OUT_REG(g == 2 ? 0 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .data_in(data_in), .key_in(key_in), .decrypt(decrypt), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .data_out(dout[g]), .busy(busy[g]));
  end

  // Reference: precomputed subkey list, reversed for decryption; E and FP derived by formula/inversion.
  function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk, input bit dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] e;
    logic [63:0] x, y, pre;
    logic [31:0] l, r, s, f, t;
    logic [5:0]  b;
    int          row_col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-M_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < ((n == 0 || n == 1 || n == 8 || n == 15) ? 1 : 2); j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-M_PC2[i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = blk[64-M_IP[i]];
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int g = 0; g < 8; g++)
        for (int k = 0; k < 6; k++) e[47-(6*g+k)] = r[31-((4*g+k+31)%32)];
      e = e ^ ks[dec ? 15 - n : n];
      for (int g = 0; g < 8; g++) begin
        b = e[47-6*g -: 6];
        row_col = {b[5], b[0]} * 16 + b[4:1];
        s[31-4*g -: 4] = M_SB[g][255-4*row_col -: 4];
      end
      for (int i = 0; i < 32; i++) f[31-i] = s[32-M_P[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) y[64-M_IP[i]] = pre[63-i];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a block and return at the negedge after the accept edge.
  task automatic start(input int u, input logic [63:0] k, input logic [63:0] x, input bit dec);
    int n;
    @(negedge clk);
    key_in = k; data_in = x; decrypt = dec; in_valid[u] = 1'b1;
    n = 0;
    while (!in_ready[u] && n < 50) begin @(negedge clk); n++; end
    chk("accept ready", in_ready[u], 1);
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0; decrypt = ~dec; data_in = ~x; key_in = ~k;
  endtask

  task automatic finish(input int u, input logic [63:0] exp, input int lat, input string tag);
    int n;
    n = 1;
    while (!out_valid[u] && n < 64) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " data"}, dout[u], exp);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk({tag, " out_valid drop"}, out_valid[u], 0);
  endtask

  task automatic run(input int u, input logic [63:0] k, input logic [63:0] x, input bit dec,
                     input logic [63:0] exp, input int lat, input string tag);
    start(u, k, x, dec);
    finish(u, exp, lat, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k, x, ct;
    int n;
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready[0], 0);
    chk("rst out_valid", out_valid[0], 0);
    chk("rst busy", busy[0], 0);
    chk("rst data_out", dout[0], 0);
    chk("rst data_out comb", dout[2], 0);
    rst_n = 1'b1;
    #1 chk("release in_ready", in_ready[0], 1);

    for (int u = 0; u < 3; u++) begin
      run(u, K1, PT1, 1'b0, CT1, LATS[u], $sformatf("kat enc rpc%0d", RPCS[u]));
      run(u, K1, CT1, 1'b1, PT1, LATS[u], $sformatf("kat dec rpc%0d", RPCS[u]));
    end
    run(0, K2, PT2, 1'b0, 64'h0, 17, "k2 enc");
    run(0, K2 ^ PAR, PT2, 1'b0, 64'h0, 17, "k2 parity flipped");

    // Backpressure, then back-to-back handoff in the consume cycle.
    start(0, K1, PT1, 1'b0);
    chk("bp busy", busy[0], 1);
    n = 1;
    while (!out_valid[0] && n < 64) begin @(negedge clk); n++; end
    chk("bp latency", 64'(n), 64'd17);
    data_in = CT1; key_in = K1; decrypt = 1'b1; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp hold data", dout[0], CT1);
      chk("bp in_ready low", in_ready[0], 0);
      chk("bp out_valid held", out_valid[0], 1);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1 chk("bp in_ready follows out_ready", in_ready[0], 1);
    @(negedge clk);
    out_ready[0] = 1'b0; in_valid[0] = 1'b0; decrypt = 1'b0; data_in = '0;
    chk("bp out_valid drop", out_valid[0], 0);
    chk("bp second busy", busy[0], 1);
    finish(0, PT1, 17, "bp second");

    // Reset in the middle of a run.
    start(0, K1, PT1, 1'b0);
    repeat (7) @(negedge clk);
    chk("mid busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", in_ready[0], 0);
    chk("mid rst out_valid", out_valid[0], 0);
    chk("mid rst busy", busy[0], 0);
    chk("mid rst data_out", dout[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid release in_ready", in_ready[0], 1);
    run(0, K1, PT1, 1'b0, CT1, 17, "post reset");

    for (int i = 0; i < 1000; i++) begin
      k  = {$urandom, $urandom};
      x  = {$urandom, $urandom};
      ct = ref_des(k, x, 1'b0);
      run(0, k, x, 1'b0, ct, 17, "rnd enc");
      run(0, k, ct, 1'b1, x, 17, "rnd dec");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
